alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  core clock, all state on rising edge.
REQ-002 SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: req0_valid  input  1  requester 0 has an operation pending.
REQ-004 SHALL have: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-005 SHALL have: req0_op1, req0_op2  input  32 each  requester 0 operands.
REQ-006 SHALL have: req0_func  input  4  requester 0 ALU function code, core Parameters.v encoding.
REQ-007 SHALL have: req1_valid, req1_ready, req1_op1, req1_op2, req1_func, identical in direction, width and meaning for requester 1.
REQ-008 SHALL have: res_valid  output  1  result register holds an undelivered result.
REQ-009 SHALL have: res_ready  input  1  consumer accepts result this cycle.
REQ-010 SHALL have: res_data  output  32  registered ALU result.
REQ-011 SHALL have: res_id  output  1  index of the requester that produced res_data.

Function
REQ-012 SHALL share one ALU datapath between two requesters; a transfer on port N occurs on an edge where reqN_valid && reqN_ready.
REQ-013 SHALL define can_accept = !res_valid || res_ready; reqN_ready = grantN && can_accept && !rst (combinational).
REQ-014 SHALL grant at most one requester per cycle; grant never depends on reqN_ready.
REQ-015 Only one valid -> that requester granted; neither valid -> no grant.
REQ-016 Both valid -> requester indicated by priority pointer granted (round-robin, see REQ-027).
REQ-017 Pointer SHALL update only on a transfer: points to the requester NOT just served; unchanged otherwise.
REQ-018 SHALL compute the result combinationally from the granted operands and latch res_data/res_id on the transfer edge; latency exactly 1 cycle (accept at edge k, res_valid high after edge k).
REQ-019 Supported functions: SLL, SRL, SRA (shift amount op2[4:0], SRA sign-filling), ADD, SUB, XOR, OR, AND, SLT (signed), SLTU, LUI (result = op2); 32-bit wrap on ADD/SUB, no overflow flag.
REQ-020 Any other func code SHALL produce res_data = 32'h0000_0000; no latches inferred.
REQ-021 res_valid set on transfer; cleared on res_valid && res_ready with no simultaneous transfer; stays set on simultaneous drain + transfer (full throughput, 1 op/cycle).
REQ-022 While res_valid && !res_ready, res_data and res_id SHALL hold stable and both reqN_ready SHALL be 0.
REQ-023 A requester SHALL NOT lose a pending request: a valid not granted keeps its ready at 0 and is served no later than the second transfer after it became valid (round-robin mode).

Reset
REQ-024 rst asserted SHALL asynchronously force res_valid=0, res_data=0, res_id=0, pointer=requester 0; req0_ready=req1_ready=0 while rst high.
REQ-025 rst asserted mid-operation SHALL discard any held result; no transfer occurs on an edge where rst is high.
REQ-026 First edge after rst deasserts SHALL behave as normal with empty result register.

Configuration
REQ-027 Macro ALU_ARB_FIXED_PRIO_EN: defined -> requester 0 always wins when both valid, pointer removed, REQ-023 bound waived for requester 1; undefined -> round-robin per REQ-016/017.

Verification
REQ-028 Reset then req0 only, ADD op1=5 op2=7, res_ready=1 -> next cycle res_valid=1, res_data=12, res_id=0.
REQ-029 Both valid every cycle (req0 SUB 10-3, req1 SRA 0x80000000>>4), res_ready=1, round-robin -> results alternate id 0 (7), id 1 (0xF8000000), 0, 1...; fixed-prio build -> id 0 every cycle.
REQ-030 res_valid=1, res_ready=0 for 3 cycles with both requesters valid -> res_data constant, both ready=0; res_ready=1 -> new result next cycle.
REQ-031 SLT op1=0xFFFFFFFF op2=1 -> 1; SLTU same operands -> 0; func code not in REQ-019 list -> 0.
REQ-032 Assert rst asynchronously between edges while res_valid=1 -> res_valid=0 immediately, readies 0; after release, req1 transfer served first if only req1 valid, pointer otherwise at 0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Requester/consumer bundle for alu_arbiter: two operation requesters and one result consumer.
// The slave modport is the arbiter side; the master modport is the requester/consumer side.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_op1;
  logic [31:0] req0_op2;
  logic [3:0]  req0_func;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_op1;
  logic [31:0] req1_op2;
  logic [3:0]  req1_func;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_id;

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_func,
    input  req1_valid, req1_op1, req1_op2, req1_func,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id
  );

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_func,
    output req1_valid, req1_op1, req1_op2, req1_func,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one ALU with a single registered result slot.
// ALU_ARB_FIXED_PRIO_EN: defined -> requester 0 always wins; undefined -> round-robin pointer.
module alu_arbiter (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FUNC_W  = 4;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [FUNC_W-1:0] FN_ADD  = 4'b0000;
  localparam logic [FUNC_W-1:0] FN_SLL  = 4'b0001;
  localparam logic [FUNC_W-1:0] FN_SLT  = 4'b0010;
  localparam logic [FUNC_W-1:0] FN_SLTU = 4'b0011;
  localparam logic [FUNC_W-1:0] FN_XOR  = 4'b0100;
  localparam logic [FUNC_W-1:0] FN_SRL  = 4'b0101;
  localparam logic [FUNC_W-1:0] FN_OR   = 4'b0110;
  localparam logic [FUNC_W-1:0] FN_AND  = 4'b0111;
  localparam logic [FUNC_W-1:0] FN_SUB  = 4'b1000;
  localparam logic [FUNC_W-1:0] FN_SRA  = 4'b1101;
  localparam logic [FUNC_W-1:0] FN_LUI  = 4'b1110;

  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q,  res_data_d;
  logic              res_id_q,    res_id_d;

  logic              grant0, grant1;
  logic              can_accept;
  logic              xfer;
  logic              sel_id;
  logic [DATA_W-1:0] op1, op2;
  logic [FUNC_W-1:0] func;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0] alu_res;

  // Grant depends only on valids and the pointer, never on ready.
`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant0 = bus.req0_valid;
    grant1 = bus.req1_valid && !bus.req0_valid;
  end
`else
  logic ptr_q, ptr_d;

  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || !ptr_q);
    grant1 = bus.req1_valid && (!bus.req0_valid ||  ptr_q);
  end
`endif

  assign can_accept     = !res_valid_q || bus.res_ready;
  assign bus.req0_ready = grant0 && can_accept && !rst;
  assign bus.req1_ready = grant1 && can_accept && !rst;

  assign xfer   = (bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready);
  assign sel_id = grant1;

  // Operand mux follows the grant so the ALU sees the winner's operation.
  always_comb begin
    op1  = bus.req0_op1;
    op2  = bus.req0_op2;
    func = bus.req0_func;
    if (sel_id) begin
      op1  = bus.req1_op1;
      op2  = bus.req1_op2;
      func = bus.req1_func;
    end
  end

  assign shamt = op2[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    unique case (func)
      FN_ADD:  alu_res = op1 + op2;
      FN_SUB:  alu_res = op1 - op2;
      FN_SLL:  alu_res = op1 << shamt;
      FN_SRL:  alu_res = op1 >> shamt;
      FN_SRA:  alu_res = DATA_W'($signed(op1) >>> shamt);
      FN_XOR:  alu_res = op1 ^ op2;
      FN_OR:   alu_res = op1 | op2;
      FN_AND:  alu_res = op1 & op2;
      FN_SLT:  alu_res = DATA_W'($signed(op1) < $signed(op2));
      FN_SLTU: alu_res = DATA_W'(op1 < op2);
      FN_LUI:  alu_res = op2;
      default: alu_res = '0;
    endcase
  end

  // Result slot: a new transfer overwrites, a drain without transfer empties it.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    if (xfer) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_res;
      res_id_d    = sel_id;
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Pointer names the requester not just served; it moves only on a transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = !sel_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`endif

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter; reference ALU and arbitration model in the bench.
module tb_alu_arbiter;
  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SLL  = 4'b0001;
  localparam logic [3:0] FN_SLT  = 4'b0010;
  localparam logic [3:0] FN_SLTU = 4'b0011;
  localparam logic [3:0] FN_XOR  = 4'b0100;
  localparam logic [3:0] FN_SRL  = 4'b0101;
  localparam logic [3:0] FN_OR   = 4'b0110;
  localparam logic [3:0] FN_AND  = 4'b0111;
  localparam logic [3:0] FN_SUB  = 4'b1000;
  localparam logic [3:0] FN_SRA  = 4'b1101;
  localparam logic [3:0] FN_LUI  = 4'b1110;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  typedef struct packed {
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  exp_t q[$];
  logic m_valid = 1'b0;
  logic m_ptr   = 1'b0;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f)
      FN_ADD:  return a + b;
      FN_SUB:  return a + ~b + 32'd1;
      FN_SLL:  return a << sh;
      FN_SRL:  return a >> sh;
      FN_SRA:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      FN_XOR:  return a ^ b;
      FN_OR:   return a | b;
      FN_AND:  return a & b;
      FN_SLT:  return {31'd0, (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)};
      FN_SLTU: return {31'd0, a < b};
      FN_LUI:  return b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_req0(input logic v, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b);
    bus.req0_valid = v; bus.req0_func = f; bus.req0_op1 = a; bus.req0_op2 = b;
  endtask

  task automatic set_req1(input logic v, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b);
    bus.req1_valid = v; bus.req1_func = f; bus.req1_op1 = a; bus.req1_op2 = b;
  endtask

  // One clock: check readies and the held result at negedge, update the model, cross the edge.
  task automatic cycle();
    logic g0, g1, can, r0, r1;
    logic [31:0] e;
    @(negedge clk);
`ifdef ALU_ARB_FIXED_PRIO_EN
    g0 = bus.req0_valid;
    g1 = bus.req1_valid && !bus.req0_valid;
`else
    g0 = bus.req0_valid && (!bus.req1_valid || !m_ptr);
    g1 = bus.req1_valid && (!bus.req0_valid ||  m_ptr);
`endif
    can = !m_valid || bus.res_ready;
    r0  = g0 && can;
    r1  = g1 && can;
    chk("res_valid", 32'(bus.res_valid), 32'(m_valid));
    chk("req0_ready", 32'(bus.req0_ready), 32'(r0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(r1));
    if (m_valid && q.size() > 0) begin
      chk("sb_data", bus.res_data, q[0].data);
      chk("sb_id", 32'(bus.res_id), 32'(q[0].id));
      if (bus.res_ready) void'(q.pop_front());
    end
    if (r0) begin
      e = ref_alu(bus.req0_func, bus.req0_op1, bus.req0_op2);
      q.push_back('{id: 1'b0, data: e});
      m_ptr = 1'b1; m_valid = 1'b1;
    end else if (r1) begin
      e = ref_alu(bus.req1_func, bus.req1_op1, bus.req1_op2);
      q.push_back('{id: 1'b1, data: e});
      m_ptr = 1'b0; m_valid = 1'b1;
    end else if (bus.res_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[11];
  logic [31:0] held;

  initial begin
    vecs = '{
      '{f: FN_SLT,  a: 32'hFFFF_FFFF, b: 32'h1,         r: 32'h1},
      '{f: FN_SLTU, a: 32'hFFFF_FFFF, b: 32'h1,         r: 32'h0},
      '{f: 4'b1111, a: 32'h1234_5678, b: 32'h1,         r: 32'h0},
      '{f: 4'b1001, a: 32'h5,         b: 32'h7,         r: 32'h0},
      '{f: FN_SLL,  a: 32'h1,         b: 32'd33,        r: 32'h2},
      '{f: FN_SRL,  a: 32'h8000_0000, b: 32'd31,        r: 32'h1},
      '{f: FN_XOR,  a: 32'h0000_F0F0, b: 32'h0000_FF00, r: 32'h0000_0FF0},
      '{f: FN_OR,   a: 32'h0000_F0F0, b: 32'h0000_FF00, r: 32'h0000_FFF0},
      '{f: FN_AND,  a: 32'h0000_F0F0, b: 32'h0000_FF00, r: 32'h0000_F000},
      '{f: FN_ADD,  a: 32'hFFFF_FFFF, b: 32'h1,         r: 32'h0},
      '{f: FN_SUB,  a: 32'h0,         b: 32'h1,         r: 32'hFFFF_FFFF}
    };
    set_req0(1'b0, FN_ADD, 32'h0, 32'h0);
    set_req1(1'b0, FN_ADD, 32'h0, 32'h0);
    bus.res_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
    chk("rst_res_data", bus.res_data, 32'h0);
    chk("rst_res_id", 32'(bus.res_id), 32'h0);
    set_req0(1'b1, FN_ADD, 32'd1, 32'd1);
    #1;
    chk("rst_req0_ready", 32'(bus.req0_ready), 32'h0);
    set_req0(1'b0, FN_ADD, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single ADD from requester 0
    set_req0(1'b1, FN_ADD, 32'd5, 32'd7);
    cycle();
    chk("add_valid", 32'(bus.res_valid), 32'h1);
    chk("add_data", bus.res_data, 32'd12);
    chk("add_id", 32'(bus.res_id), 32'h0);
    set_req0(1'b0, FN_ADD, 32'h0, 32'h0);

    // Requester 1 alone (LUI) returns the pointer to requester 0
    set_req1(1'b1, FN_LUI, 32'h0, 32'hABCD_0000);
    cycle();
    chk("lui_data", bus.res_data, 32'hABCD_0000);
    chk("lui_id", 32'(bus.res_id), 32'h1);

    // Both valid every cycle
    set_req0(1'b1, FN_SUB, 32'd10, 32'd3);
    set_req1(1'b1, FN_SRA, 32'h8000_0000, 32'd4);
    for (int i = 0; i < 6; i++) begin
      cycle();
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("both_id", 32'(bus.res_id), 32'h0);
      chk("both_data", bus.res_data, 32'd7);
`else
      chk("both_id", 32'(bus.res_id), 32'(i % 2));
      chk("both_data", bus.res_data, (i % 2 == 1) ? 32'hF800_0000 : 32'd7);
`endif
    end

    // Backpressure with both requesters pending
`ifdef ALU_ARB_FIXED_PRIO_EN
    held = 32'd7;
`else
    held = 32'hF800_0000;
`endif
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_data", bus.res_data, held);
    end
    bus.res_ready = 1'b1;
    cycle();
    chk("release_id", 32'(bus.res_id), 32'h0);
    chk("release_data", bus.res_data, 32'd7);
    set_req1(1'b0, FN_ADD, 32'h0, 32'h0);

    // Function table from requester 0, back-to-back
    for (int i = 0; i < 11; i++) begin
      set_req0(1'b1, vecs[i].f, vecs[i].a, vecs[i].b);
      cycle();
      chk($sformatf("func_%0d", i), bus.res_data, vecs[i].r);
    end

    // Async reset while a result is held; pointer was left at requester 1
    bus.res_ready = 1'b0;
    set_req0(1'b0, FN_ADD, 32'h0, 32'h0);
    set_req1(1'b1, FN_ADD, 32'd1, 32'd2);
    #1;
    chk("pre_rst_valid", 32'(bus.res_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.res_valid), 32'h0);
    chk("arst_data", bus.res_data, 32'h0);
    chk("arst_req0_ready", 32'(bus.req0_ready), 32'h0);
    chk("arst_req1_ready", 32'(bus.req1_ready), 32'h0);
    q.delete();
    m_valid = 1'b0;
    m_ptr   = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_no_xfer", 32'(bus.res_valid), 32'h0);
    set_req1(1'b0, FN_ADD, 32'h0, 32'h0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(bus.res_valid), 32'h0);

    set_req0(1'b1, FN_ADD, 32'd100, 32'd1);
    set_req1(1'b1, FN_XOR, 32'hFF, 32'h0F);
    cycle();
    chk("post_rst_ptr_id", 32'(bus.res_id), 32'h0);
    chk("post_rst_ptr_data", bus.res_data, 32'd101);
    set_req0(1'b0, FN_ADD, 32'h0, 32'h0);
    cycle();
    chk("post_rst_req1_id", 32'(bus.res_id), 32'h1);
    chk("post_rst_req1_data", bus.res_data, 32'hF0);
    set_req1(1'b0, FN_ADD, 32'h0, 32'h0);
    cycle();
    cycle();
    chk("sb_empty", 32'(q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
